// File: rtl/fir_sum_pipe_if.sv
// Stream bundle for fir_sum_pipe: sample input handshake plus window-sum output handshake.
// The master side is the sample source / downstream sink pair; the slave side is the filter.
// out_sum is a raw OW-bit pattern. When FIR_SIGNED_EN is defined it is read as two's complement.
interface fir_sum_pipe_if #(
    parameter int W    = 16,
    parameter int TAPS = 4
);
    localparam int OW = W + $clog2(TAPS);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_sum;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum
    );
endinterface

// File: rtl/fir_sum_pipe.sv
// fir_sum_pipe: TAPS-deep unweighted moving-window sum of a W-bit sample stream.
// Pipeline stages are the tap chain, then one register per adder-tree level, then a
// registered output. The first sum appears 1 + $clog2(TAPS) edges after the accept edge.
// The whole pipeline advances together and freezes while the output is stalled.
// Build option FIR_SIGNED_EN: when defined, samples are two's complement and are
// sign-extended into the tree. When undefined (the default), samples are zero-extended.
module fir_sum_pipe #(
    parameter int W    = 16,
    parameter int TAPS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    fir_sum_pipe_if.slave bus
);
    localparam int OW    = W + $clog2(TAPS);
    localparam int L     = $clog2(TAPS);
    localparam int NLEAF = 1 << L;
    localparam int CW    = $clog2(TAPS + 1);
    localparam logic [CW-1:0] TAPS_C = CW'(TAPS);

    // Every node is carried at full output width. That makes the result exact at each
    // level without needing per-level width bookkeeping.
    function automatic logic [OW-1:0] ext(input logic [W-1:0] x);
`ifdef FIR_SIGNED_EN
        return {{(OW - W){x[W-1]}}, x};
`else
        return {{(OW - W){1'b0}}, x};
`endif
    endfunction

    logic [W-1:0]  taps_q [TAPS];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          win_full_d;

    // The tree uses heap indexing. Node i has children 2i and 2i+1, and the root is node 1.
    // Indices NLEAF/2..NLEAF-1 form the first level and are fed directly from the leaves.
    logic [OW-1:0] leaf   [NLEAF];
    logic [OW-1:0] node_q [1:NLEAF-1];
    logic [L:0]    vld_q;

    logic          out_valid_q;
    logic [OW-1:0] out_sum_q;

    logic stall;
    logic in_ready;
    logic accept;
    logic clear;

    assign stall    = out_valid_q && !bus.out_ready;
    assign in_ready = reset_n && !flush && !stall;
    assign accept   = bus.in_valid && in_ready;
    assign clear    = !reset_n || flush;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;

    // The fill counter saturates at TAPS. Only an accept that completes the window yields a valid sum.
    always_comb begin
        cnt_d      = (cnt_q == TAPS_C) ? TAPS_C : cnt_q + 1'b1;
        win_full_d = (cnt_d == TAPS_C);
    end

    // Leaves come from the tap chain. Leaves past TAPS are padded with zero.
    always_comb begin
        for (int i = 0; i < NLEAF; i++) begin
            leaf[i] = '0;
        end
        for (int i = 0; i < TAPS; i++) begin
            leaf[i] = ext(taps_q[i]);
        end
    end

    // Tap chain and fill counter: both move only on an accepted sample, and are cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else if (accept) begin
            cnt_q     <= cnt_d;
            taps_q[0] <= bus.in_data;
            for (int i = 1; i < TAPS; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    // Adder tree and its valid pipeline: advance whenever not stalled. A non-accept cycle enters as a bubble.
    always_ff @(posedge clk) begin
        if (clear) begin
            vld_q <= '0;
            for (int i = 1; i < NLEAF; i++) begin
                node_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q <= {vld_q[L-1:0], accept && win_full_d};
            for (int i = NLEAF / 2; i < NLEAF; i++) begin
                node_q[i] <= leaf[2*i - NLEAF] + leaf[2*i - NLEAF + 1];
            end
            for (int i = 1; i < NLEAF / 2; i++) begin
                node_q[i] <= node_q[2*i] + node_q[2*i + 1];
            end
        end
    end

    // Registered output: holds steady while the downstream is not ready.
    always_ff @(posedge clk) begin
        if (clear) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else if (!stall) begin
            out_valid_q <= vld_q[L];
            out_sum_q   <= node_q[1];
        end
    end
endmodule

// File: tb/tb_fir_sum_pipe.sv
// Directed and random bench for fir_sum_pipe.
// There are two instances: TAPS=4 (directed steps) and TAPS=5 (same stimulus).
// A per-instance window model pushes expected sums on accept, and these are popped on each output handshake.
module tb_fir_sum_pipe;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [31:0] q4[$];
    logic [31:0] q5[$];
    int          w4[$];
    int          w5[$];

    fir_sum_pipe_if #(.W(16), .TAPS(4)) b4 ();
    fir_sum_pipe_if #(.W(16), .TAPS(5)) b5 ();

    assign b4.in_valid  = in_valid;
    assign b4.in_data   = in_data;
    assign b4.out_ready = out_ready;
    assign b5.in_valid  = in_valid;
    assign b5.in_data   = in_data;
    assign b5.out_ready = out_ready;

    fir_sum_pipe #(.W(16), .TAPS(4)) u4 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b4));
    fir_sum_pipe #(.W(16), .TAPS(5)) u5 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mext(input logic [15:0] d);
`ifdef FIR_SIGNED_EN
        return int'($signed(d));
`else
        return int'({16'h0, d});
`endif
    endfunction

    // Model and scoreboard for the TAPS=4 instance.
    always @(negedge clk) begin
        if (b4.out_valid === 1'b1 && out_ready) begin
            if (q4.size() == 0) chk("u4_unexpected_valid", 32'(b4.out_valid), 32'd0);
            else chk("u4_sum", 32'(b4.out_sum), q4.pop_front());
        end
        if (!reset_n || flush) begin
            q4.delete();
            w4.delete();
        end else if (in_valid && b4.in_ready === 1'b1) begin
            w4.push_back(mext(in_data));
            if (w4.size() > 4) void'(w4.pop_front());
            if (w4.size() == 4) q4.push_back(32'(w4.sum()) & 32'h3FFFF);
        end
    end

    // Model and scoreboard for the TAPS=5 instance.
    always @(negedge clk) begin
        if (b5.out_valid === 1'b1 && out_ready) begin
            if (q5.size() == 0) chk("u5_unexpected_valid", 32'(b5.out_valid), 32'd0);
            else chk("u5_sum", 32'(b5.out_sum), q5.pop_front());
        end
        if (!reset_n || flush) begin
            q5.delete();
            w5.delete();
        end else if (in_valid && b5.in_ready === 1'b1) begin
            w5.push_back(mext(in_data));
            if (w5.size() > 5) void'(w5.pop_front());
            if (w5.size() == 5) q5.push_back(32'(w5.sum()) & 32'h7FFFF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (b4.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("send_in_ready_timeout", 32'(b4.in_ready), 32'd1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (b4.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(b4.out_valid), 32'd1);
    endtask

    initial begin
        int a4;
        logic [17:0] held;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(b4.in_ready), 32'd0);
        chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_out_sum", 32'(b4.out_sum), 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(b4.in_ready), 32'd1);
        tick();

        // Step 1: samples 1..5 back-to-back. Expect sums 10 and 14, with first output LAT after sample 4.
        send(16'd1);
        send(16'd2);
        send(16'd3);
        send(16'd4);
        a4 = last_acc;
        send(16'd5);
        wait_out("t1_valid");
        chk("t1_latency", 32'(cyc - a4), 32'd3);
        chk("t1_first_sum", 32'(b4.out_sum), 32'd10);
        repeat (6) tick();

        // Step 2: the maximum sample value must not wrap.
        for (int i = 0; i < 8; i++) send(16'hFFFF);
        chk("t2_valid", 32'(b4.out_valid), 32'd1);
        chk("t2_max_sum", 32'(b4.out_sum), 32'h3FFFC);
        repeat (6) tick();

        // Step 3: five cycles of backpressure, with a sample waiting at the input.
        for (int i = 11; i <= 15; i++) send(16'(i));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd16;
        held      = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_in_ready", 32'(b4.in_ready), 32'd0);
            if (i == 0) begin
                chk("t3_stall_valid", 32'(b4.out_valid), 32'd1);
                held = b4.out_sum;
            end else begin
                chk("t3_sum_held", 32'(b4.out_sum), 32'(held));
            end
        end
        tick();
        out_ready = 1'b1;
        send(16'd16);
        send(16'd17);
        send(16'd18);

        // Step 4: flush with a sample presented in the same cycle. The window then needs four new samples.
        for (int i = 1; i <= 6; i++) send(16'(i));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd99;
        @(negedge clk);
        chk("t4_flush_in_ready", 32'(b4.in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_flush_out_valid", 32'(b4.out_valid), 32'd0);
        send(16'd10);
        send(16'd20);
        send(16'd30);
        repeat (5) tick();
        chk("t4_no_early_out", 32'(b4.out_valid), 32'd0);
        send(16'd40);
        wait_out("t4_valid");
        chk("t4_sum_100", 32'(b4.out_sum), 32'd100);
        repeat (4) tick();

        // Step 5: a one-cycle reset while sums are in flight.
        for (int i = 1; i <= 5; i++) send(16'(i));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t5_rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("t5_rst_out_sum", 32'(b4.out_sum), 32'd0);
        send(16'd7);
        send(16'd8);
        send(16'd9);
        repeat (5) tick();
        chk("t5_no_early_out", 32'(b4.out_valid), 32'd0);
        send(16'd10);
        wait_out("t5_valid");
        chk("t5_sum_34", 32'(b4.out_sum), 32'd34);
        repeat (4) tick();

        // Step 6: four all-ones samples from a clean window.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        wait_out("t6_valid");
        chk("t6_all_ones", 32'(b4.out_sum), 32'h3FFFC);
        repeat (4) tick();

        // Random stream with bubbles, backpressure and occasional flush. Both instances are checked by scoreboard.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        chk("u4_all_drained", 32'(q4.size()), 32'd0);
        chk("u5_all_drained", 32'(q5.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
